nios_system_sysid_check: RTL and testbench

NIOS_SYSTEM_SYSID_CHECK -- requirements
Module: nios_system_sysid_check

---
 rtl/nios_system_sysid_pkg.sv | 26 ++
 rtl/nios_system_sysid_phase_timer.sv | 30 +++
 rtl/nios_system_sysid_check.sv | 129 ++++++++++++
 tb/tb_nios_system_sysid_check.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_sysid_pkg.sv
// Shared definitions for the sysid check block: FSM encoding, sysid word
// addresses and the registered Avalon-MM command bundle.
package nios_system_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        RSP_ID,
        REQ_TS,
        RSP_TS,
        FIN
    } state_t;

    localparam logic ID_ADDR = 1'b0;
    localparam logic TS_ADDR = 1'b1;

    typedef struct packed {
        logic read;
        logic address;
    } avm_cmd_t;

    function automatic logic is_access(input state_t s);
        return (s == REQ_ID) || (s == RSP_ID) || (s == REQ_TS) || (s == RSP_TS);
    endfunction

endpackage

// File: rtl/nios_system_sysid_phase_timer.sv
// Per-phase cycle counter; expired flags the TIMEOUT_CYCLES-th cycle of a phase.
module nios_system_sysid_phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;
    logic [15:0] base;

    // clear arrives in the first cycle of a new state, so the stale count is
    // masked here rather than a cycle late.
    assign base    = clear ? 16'd0 : count;
    assign expired = enable && (base == LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= 16'd0;
        end else begin
            count <= base + {15'd0, enable};
        end
    end

endmodule

// File: rtl/nios_system_sysid_check.sv
// Reads the sysid slave (ID at word 0, timestamp at word 1) and compares both
// words against the values expected for this build, with a per-phase timeout.
module nios_system_sysid_check
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1449275721,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t   state;
    avm_cmd_t cmd;
    logic     phase_new;
    logic     expired;
    logic     in_phase;
    logic     is_req;
    logic     is_id;
    logic     capture;
    logic     accept_only;
    logic     abort;

    assign avm_read    = cmd.read;
    assign avm_address = cmd.address;

    assign in_phase = is_access(state);
    assign is_req   = (state == REQ_ID) || (state == REQ_TS);
    assign is_id    = (state == REQ_ID) || (state == RSP_ID);
    // A zero-latency slave returns data in the acceptance cycle itself.
    assign capture     = in_phase && avm_readdatavalid && (!is_req || !avm_waitrequest);
    assign accept_only = is_req && !avm_waitrequest && !avm_readdatavalid;
    assign abort       = in_phase && expired && !capture && !accept_only;

    nios_system_sysid_phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (phase_new),
        .enable  (in_phase),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= 32'd0;
            ts_value  <= 32'd0;
            phase_new <= 1'b0;
        end else begin
            done      <= 1'b0;
            phase_new <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        id_ok     <= 1'b0;
                        ts_ok     <= 1'b0;
                        timeout   <= 1'b0;
                        cmd       <= '{read: 1'b1, address: ID_ADDR};
                        busy      <= 1'b1;
                        state     <= REQ_ID;
                        phase_new <= 1'b1;
                    end
                end
                REQ_ID, RSP_ID, REQ_TS, RSP_TS: begin
                    if (capture) begin
                        phase_new <= 1'b1;
                        if (is_id) begin
                            id_value <= avm_readdata;
                            cmd      <= '{read: 1'b1, address: TS_ADDR};
                            state    <= REQ_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            cmd.read <= 1'b0;
                            state    <= FIN;
                        end
                    end else if (accept_only) begin
                        phase_new <= 1'b1;
                        cmd.read  <= 1'b0;
                        state     <= is_id ? RSP_ID : RSP_TS;
                    end else if (abort) begin
                        phase_new <= 1'b1;
                        timeout   <= 1'b1;
                        cmd.read  <= 1'b0;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    // A timed-out check leaves both ok flags cleared.
                    if (!timeout) begin
                        id_ok <= (id_value == EXPECTED_ID);
                        ts_ok <= (ts_value == EXPECTED_TS);
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                    phase_new <= 1'b1;
                end
                default: begin
                    cmd   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_check.sv
// Directed bench: behavioural sysid slave, expectations queued at start and
// retired when done pulses. Cycle 1 is the cycle in which start is driven.
module tb_nios_system_sysid_check;

    localparam logic [31:0] TS = 32'd1449275721;

    logic        clock = 1'b0;
    logic        reset_n, start;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    logic [31:0] mem0, mem1;
    logic        stuck, stray, pend_addr = 1'b0;
    int          lat, stall_until;
    int          cyc = 0;
    int          pend = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        logic [31:0] id_v;
        logic [31:0] ts_v;
        int          done_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    nios_system_sysid_check #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    // Slave model: stall window, fixed read latency, optional stray valid.
    always_comb begin
        avm_waitrequest   = stuck || (cyc < stall_until);
        avm_readdatavalid = stray;
        avm_readdata      = 32'hA5A5_5A5A;
        if (lat == 0 && avm_read && !avm_waitrequest) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = avm_address ? mem1 : mem0;
        end else if (pend == 1) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_addr ? mem1 : mem0;
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (avm_read && !avm_waitrequest && lat > 0) begin
            pend      <= lat;
            pend_addr <= avm_address;
        end else if (pend > 0) begin
            pend <= pend - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 of cycle 2.
    task automatic start_check(input logic eid, input logic ets, input logic eto,
                               input logic [31:0] eidv, input logic [31:0] etsv,
                               input int done_at);
        exp_t e;
        start = 1'b1;
        e = '{id_ok: eid, ts_ok: ets, timeout: eto, id_v: eidv, ts_v: etsv,
              done_cyc: cyc + done_at - 1};
        sb.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        exp_t e;
        logic prev_read = 1'b0;
        logic prev_wr   = 1'b0;
        logic prev_addr = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (prev_read && prev_wr) begin
                chk("stall_read_held", avm_read, 1);
                chk("stall_addr_held", avm_address, prev_addr);
            end
            prev_read = avm_read;
            prev_wr   = avm_waitrequest;
            prev_addr = avm_address;
            chk("busy_vs_done", busy ^ done, 1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("id_ok", id_ok, e.id_ok);
                    chk("ts_ok", ts_ok, e.ts_ok);
                    chk("timeout", timeout, e.timeout);
                    chk("id_value", id_value, e.id_v);
                    chk("ts_value", ts_value, e.ts_v);
                end
                return;
            end
        end
        chk("done_within_budget", done, 1);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("no_extra_done", done, 0);
        end
        @(posedge clock); #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_read"}, avm_read, 0);
        chk({tag, "_addr"}, avm_address, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_id_ok"}, id_ok, 0);
        chk({tag, "_ts_ok"}, ts_ok, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_id_value"}, id_value, 0);
        chk({tag, "_ts_value"}, ts_value, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stuck = 1'b0; stray = 1'b0;
        lat = 0; stall_until = 0; mem0 = 32'd0; mem1 = TS;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_state("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Zero-wait, zero-latency slave with matching words.
        start_check(1, 1, 0, 32'd0, TS, 5);
        wait_done(20);
        quiet(3);

        // Wrong ID.
        mem0 = 32'h0000_0001;
        start_check(0, 1, 0, 32'h0000_0001, TS, 5);
        wait_done(20);
        quiet(3);

        // Stuck waitrequest: 8 cycles of read in REQ_ID, then abort.
        mem0  = 32'd0;
        stuck = 1'b1;
        start_check(0, 0, 1, 32'h0000_0001, TS, 11);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("stuck_read_high", avm_read, 1);
            chk("stuck_addr", avm_address, 0);
        end
        @(negedge clock);
        chk("read_dropped", avm_read, 0);
        chk("read_dropped_busy", busy, 1);
        wait_done(5);
        stuck = 1'b0;
        quiet(3);

        // Three stalled cycles from start, two-cycle read latency on both reads.
        lat = 2;
        stall_until = cyc + 3;
        start_check(1, 1, 0, 32'd0, TS, 11);
        wait_done(30);
        quiet(3);

        // Second start while busy is ignored.
        lat = 0;
        start_check(1, 1, 0, 32'd0, TS, 5);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(10);
        quiet(8);

        // Reset during RSP_TS; the slave's late valid and a stray pulse follow.
        lat  = 2;
        mem0 = 32'h1234_5678;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rsp_ts_read_low", avm_read, 0);
        chk("rsp_ts_busy", busy, 1);
        chk("rsp_ts_id_value", id_value, 32'h1234_5678);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk_reset_state("abort");
        @(posedge clock); #1;
        stray = 1'b1;
        @(negedge clock);
        chk("stray_ts_value", ts_value, 0);
        chk("stray_busy", busy, 0);
        @(posedge clock); #1;
        stray = 1'b0;
        quiet(3);
        chk("post_abort_ts_value", ts_value, 0);
        chk("post_abort_read", avm_read, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
